// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : Clocked register file with two registered read ports (x, y),
//                one write port (z), same-cycle write-to-read bypass, an
//                optional hardwired zero register and a per-register busy
//                scoreboard for operand-availability stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module register_file #(
   parameter int b        = 8,   // data width
   parameter int N_b      = 4,   // select width, depth = 2**N_b
   parameter int ZERO_REG = 0    // 1: register 0 reads 0, is never written or busy
) (
   input  logic           clk,
   input  logic           rst_n,
   output logic [b-1:0]   x,
   output logic [b-1:0]   y,
   input  logic [b-1:0]   z,
   input  logic           x_enb,
   input  logic           y_enb,
   input  logic           z_enb,
   input  logic [N_b-1:0] x_sel,
   input  logic [N_b-1:0] y_sel,
   input  logic [N_b-1:0] z_sel,
   input  logic           busy_set,
   input  logic [N_b-1:0] busy_sel,
   output logic           x_busy,
   output logic           y_busy
);

   localparam int D  = 2**N_b;
   localparam bit ZR = (ZERO_REG != 0);

   logic [b-1:0] regs_q [D];
   logic [D-1:0] wr_en;
   logic [D-1:0] busy_q;
   logic [D-1:0] busy_d;
   logic [b-1:0] x_q, x_d;
   logic [b-1:0] y_q, y_d;

   // Per-register write-enable decode and scoreboard next-state.
   // A busy_set to the same index as the clearing write wins, since it
   // represents a newly issued producer for that register.
   for (genvar i = 0; i < D; i++) begin : g_reg
      localparam logic [N_b-1:0] IDX = N_b'(i);
      if (ZR && (i == 0)) begin : g_zero
         assign wr_en[i]  = 1'b0;
         assign busy_d[i] = 1'b0;
      end else begin : g_norm
         assign wr_en[i]  = z_enb && (z_sel == IDX);
         assign busy_d[i] = (busy_set && (busy_sel == IDX)) ? 1'b1 :
                            wr_en[i]                        ? 1'b0 :
                                                              busy_q[i];
      end
   end

   // Storage array: write z into the addressed register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < D; i++) begin
            if (wr_en[i]) regs_q[i] <= z;
         end
      end
   end

   // Read-port next values: hold when disabled, zero register reads 0,
   // otherwise a same-edge write to the same address is forwarded.
   always_comb begin
      x_d = x_q;
      if (x_enb) begin
         if (ZR && (x_sel == '0))            x_d = '0;
         else if (z_enb && (z_sel == x_sel)) x_d = z;
         else                                x_d = regs_q[x_sel];
      end
      y_d = y_q;
      if (y_enb) begin
         if (ZR && (y_sel == '0))            y_d = '0;
         else if (z_enb && (z_sel == y_sel)) y_d = z;
         else                                y_d = regs_q[y_sel];
      end
   end

   // Registered read outputs and busy scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= '0;
         y_q    <= '0;
         busy_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         busy_q <= busy_d;
      end
   end

   assign x = x_q;
   assign y = y_q;

   // A write to the operand this cycle satisfies it via bypass, so it is
   // no longer reported busy.
   assign x_busy = busy_q[x_sel] && !(z_enb && (z_sel == x_sel));
   assign y_busy = busy_q[y_sel] && !(z_enb && (z_sel == y_sel));

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Directed self-checking bench for register_file with default,
//                zero-register and wide/deep instances.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_register_file;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // default instance (b=8, N_b=4, ZERO_REG=0)
   logic [7:0] d_x, d_y, d_z;
   logic       d_xe, d_ye, d_ze, d_bs, d_xb, d_yb;
   logic [3:0] d_xs, d_ys, d_zs, d_bsel;

   // zero-register instance
   logic [7:0] r_x, r_y, r_z;
   logic       r_xe, r_ye, r_ze, r_bs, r_xb, r_yb;
   logic [3:0] r_xs, r_ys, r_zs, r_bsel;

   // wide instance (b=16, N_b=5)
   logic [15:0] w_x, w_y, w_z;
   logic        w_xe, w_ye, w_ze, w_bs, w_xb, w_yb;
   logic [4:0]  w_xs, w_ys, w_zs, w_bsel;

   register_file u_dut (
      .clk(clk), .rst_n(rst_n), .x(d_x), .y(d_y), .z(d_z),
      .x_enb(d_xe), .y_enb(d_ye), .z_enb(d_ze),
      .x_sel(d_xs), .y_sel(d_ys), .z_sel(d_zs),
      .busy_set(d_bs), .busy_sel(d_bsel), .x_busy(d_xb), .y_busy(d_yb));

   register_file #(.b(8), .N_b(4), .ZERO_REG(1)) u_zero (
      .clk(clk), .rst_n(rst_n), .x(r_x), .y(r_y), .z(r_z),
      .x_enb(r_xe), .y_enb(r_ye), .z_enb(r_ze),
      .x_sel(r_xs), .y_sel(r_ys), .z_sel(r_zs),
      .busy_set(r_bs), .busy_sel(r_bsel), .x_busy(r_xb), .y_busy(r_yb));

   register_file #(.b(16), .N_b(5), .ZERO_REG(0)) u_wide (
      .clk(clk), .rst_n(rst_n), .x(w_x), .y(w_y), .z(w_z),
      .x_enb(w_xe), .y_enb(w_ye), .z_enb(w_ze),
      .x_sel(w_xs), .y_sel(w_ys), .z_sel(w_zs),
      .busy_set(w_bs), .busy_sel(w_bsel), .x_busy(w_xb), .y_busy(w_yb));

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_q[$];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // expected read data queued when the read is driven
   task automatic push(input logic [15:0] e);
      exp_q.push_back(e);
   endtask

   // compare a port that has just produced its read result
   task automatic pop_chk(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $error("FAIL %s: observed %h expected <queue empty>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      {d_z, d_xe, d_ye, d_ze, d_bs, d_xs, d_ys, d_zs, d_bsel} = '0;
      {r_z, r_xe, r_ye, r_ze, r_bs, r_xs, r_ys, r_zs, r_bsel} = '0;
      {w_z, w_xe, w_ye, w_ze, w_bs, w_xs, w_ys, w_zs, w_bsel} = '0;
      tick(); tick();
      chk("rst_x", 16'(d_x), 16'h00);
      chk("rst_y", 16'(d_y), 16'h00);
      chk("rst_xbusy", 16'(d_xb), 16'h0);
      rst_n = 1'b1;

      // ---- asynchronous reset mid-operation ----
      d_z = 8'hA5; d_zs = 4'd3; d_ze = 1'b1; d_xs = 4'd3; d_xe = 1'b1;
      d_bs = 1'b1; d_bsel = 4'd4;
      push(16'h00A5);
      tick();
      pop_chk("pre_rst_bypass_x", 16'(d_x));
      d_ze = 1'b0; d_bs = 1'b0; d_xe = 1'b0; d_xs = 4'd4;
      #1 chk("pre_rst_busy4", 16'(d_xb), 16'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_x", 16'(d_x), 16'h00);
      chk("async_rst_y", 16'(d_y), 16'h00);
      chk("async_rst_busy", 16'(d_xb), 16'h0);
      #1 rst_n = 1'b1;
      d_xs = 4'd3; d_xe = 1'b1;
      push(16'h0000);
      tick();
      pop_chk("post_rst_reg3", 16'(d_x));

      // ---- write then read ----
      d_xe = 1'b0;
      d_z = 8'd1; d_zs = 4'd0; d_ze = 1'b1;
      tick();
      d_z = 8'd2; d_zs = 4'd1;
      tick();
      d_ze = 1'b0; d_xs = 4'd0; d_ys = 4'd1; d_xe = 1'b1; d_ye = 1'b1;
      push(16'd1); push(16'd2);
      tick();
      pop_chk("rd_x_reg0", 16'(d_x));
      pop_chk("rd_y_reg1", 16'(d_y));
      d_xe = 1'b0; d_xs = 4'd1; d_ys = 4'd0;
      push(16'd1); push(16'd1);
      tick();
      pop_chk("hold_x", 16'(d_x));
      pop_chk("rd_y_reg0", 16'(d_y));

      // ---- bypass, both ports on the same register ----
      d_z = 8'h3C; d_zs = 4'd5; d_ze = 1'b1;
      d_xs = 4'd5; d_ys = 4'd5; d_xe = 1'b1; d_ye = 1'b1;
      push(16'h3C); push(16'h3C);
      tick();
      pop_chk("bypass_x", 16'(d_x));
      pop_chk("bypass_y", 16'(d_y));

      // ---- scoreboard ----
      d_ze = 1'b0; d_xe = 1'b0; d_ye = 1'b0;
      d_bs = 1'b1; d_bsel = 4'd7; d_xs = 4'd7; d_ys = 4'd7;
      tick();
      d_bs = 1'b0;
      #1;
      chk("busy_set_x", 16'(d_xb), 16'h1);
      chk("busy_set_y", 16'(d_yb), 16'h1);
      d_z = 8'h11; d_zs = 4'd7; d_ze = 1'b1;
      #1 chk("busy_comb_clear", 16'(d_xb), 16'h0);
      tick();
      d_ze = 1'b0;
      #1 chk("busy_cleared", 16'(d_xb), 16'h0);
      d_bs = 1'b1; d_bsel = 4'd7; d_z = 8'h22; d_zs = 4'd7; d_ze = 1'b1;
      tick();
      d_bs = 1'b0; d_ze = 1'b0;
      #1 chk("busy_set_wins", 16'(d_xb), 16'h1);
      d_bs = 1'b1; d_bsel = 4'd2; d_z = 8'h33; d_zs = 4'd7; d_ze = 1'b1;
      tick();
      d_bs = 1'b0; d_ze = 1'b0; d_xs = 4'd7; d_ys = 4'd2;
      #1;
      chk("busy_diff_clr7", 16'(d_xb), 16'h0);
      chk("busy_diff_set2", 16'(d_yb), 16'h1);
      d_xe = 1'b1; d_ye = 1'b1; d_ys = 4'd5;
      push(16'h33); push(16'h3C);
      tick();
      pop_chk("rd_reg7", 16'(d_x));
      pop_chk("rd_reg5", 16'(d_y));

      // ---- zero register ----
      r_z = 8'hFF; r_zs = 4'd0; r_ze = 1'b1; r_xs = 4'd0; r_xe = 1'b1;
      push(16'h00);
      tick();
      pop_chk("zero_bypass_x", 16'(r_x));
      r_ze = 1'b0; r_xe = 1'b0; r_ys = 4'd0; r_ye = 1'b1;
      r_bs = 1'b1; r_bsel = 4'd0;
      push(16'h00);
      tick();
      pop_chk("zero_rd_y", 16'(r_y));
      r_bs = 1'b0; r_ye = 1'b0;
      #1 chk("zero_busy", 16'(r_xb), 16'h0);
      r_z = 8'h77; r_zs = 4'd1; r_ze = 1'b1; r_ys = 4'd1; r_ye = 1'b1;
      push(16'h77);
      tick();
      pop_chk("zero_inst_reg1", 16'(r_y));
      r_ze = 1'b0; r_ye = 1'b0;

      // ---- wide / deep instance ----
      w_z = 16'hBEEF; w_zs = 5'd31; w_ze = 1'b1;
      tick();
      w_ze = 1'b0; w_xs = 5'd31; w_ys = 5'd30; w_xe = 1'b1; w_ye = 1'b1;
      push(16'hBEEF); push(16'h0000);
      tick();
      pop_chk("wide_reg31", w_x);
      pop_chk("wide_reg30", w_y);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/register_file.md
# register_file

Clocked, parametrised register file for the datapath. It has two registered read ports (x, y) and one write port (z), with same-cycle write-to-read bypass. An optional hardwired zero register is available. A per-register busy scoreboard lets the control unit stall on operands that still have a write pending. It replaces the earlier unclocked 8-bit, 16-entry register bank and keeps the x/y/z port naming.

## Interface
- b, 8, data width in bits
- N_b, 4, select width; depth D = 2**N_b registers
- ZERO_REG, 0, if 1, register 0 always reads 0, ignores writes and is never busy
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- x  out  b  read data, port x (registered)
- y  out  b  read data, port y (registered)
- z  in  b  write data
- x_enb  in  1  read enable, port x
- y_enb  in  1  read enable, port y
- z_enb  in  1  write enable
- x_sel  in  N_b  read address, port x
- y_sel  in  N_b  read address, port y
- z_sel  in  N_b  write address
- busy_set  in  1  mark register busy_sel as having a pending write
- busy_sel  in  N_b  scoreboard address
- x_busy  out  1  operand at x_sel not yet available (combinational)
- y_busy  out  1  operand at y_sel not yet available (combinational)

## Operation
- Storage: D registers of b bits, reg[0..D-1], plus busy[0..D-1].
- Write:
  - On a rising edge with z_enb=1, reg[z_sel] <= z.
  - Exception: the write is ignored when ZERO_REG=1 and z_sel=0.
- Read:
  - On a rising edge with x_enb=1, x <= value of reg[x_sel].
  - With x_enb=0, x holds its previous value. Port y behaves identically.
- Bypass:
  - If x_enb=1, z_enb=1 and x_sel=z_sel at the same edge, x <= z (new data, not old).
  - Same rule applies to y.
  - No bypass for ZERO_REG=1 with sel=0: the port reads 0.
- Both read ports may address the same register; both return the same value.
- Scoreboard:
  - busy_set=1 at an edge sets busy[busy_sel].
  - z_enb=1 at an edge clears busy[z_sel].
  - Same edge, same index (set and clear): set wins, because a new producer has been issued.
  - Same edge, different indices: both take effect.
  - ZERO_REG=1 with busy_sel=0: no effect.
- x_busy = busy[x_sel] AND NOT (z_enb AND z_sel==x_sel). A write in progress this cycle satisfies the operand through bypass. y_busy uses the same form.
- x_busy and y_busy are independent of x_enb and y_enb.

## Timing
- Reset (rst_n=0, asynchronous):
  - All reg entries = 0, x = 0, y = 0, all busy = 0.
  - x_busy = y_busy = 0.
  - Writes and busy_set are ignored while rst_n=0.
- Reset asserted mid-operation clears all state immediately, without waiting for an edge.
- The first edge after rst_n rises operates normally.
- Read latency: 1 cycle. x_sel and x_enb sampled at edge n give x valid after edge n.
- Write latency: 1 cycle. A read at edge n+1 of a write at edge n returns the new data; at edge n it returns the new data through bypass.
- Busy flag:
  - busy_set at edge n makes the flag visible on x_busy/y_busy after edge n.
  - The clearing write at edge m drops x_busy combinationally during the cycle before edge m, while z_enb is high.
- Select widths are exact; every select value addresses a valid register, so there is no out-of-range case.
- No X propagation. Unused inputs are don't-care only when their enable is 0.

## Test plan
- Reset:
  - Write 0xA5 to reg 3.
  - Assert rst_n=0 between edges: x, y and all busy clear at once, with no clock edge.
  - Read reg 3 after release: x=0.
- Write/read:
  - z=1, z_sel=0, z_enb=1 for one edge; then z=2, z_sel=1.
  - x_sel=0, y_sel=1, both enabled: after the next edge x=1, y=2.
  - Drop x_enb, change x_sel: x holds 1.
- Bypass:
  - Same edge with z=0x3C, z_sel=5, z_enb=1, x_sel=y_sel=5, x_enb=y_enb=1.
  - After that edge: x=y=0x3C (old reg 5 was 0).
- Scoreboard:
  - busy_set, busy_sel=7 → x_busy=1 with x_sel=7.
  - Raise z_enb, z_sel=7: x_busy=0 in the same cycle.
  - After the edge, busy[7]=0.
  - busy_set and z_enb both to reg 7 on one edge: busy[7] stays 1.
- Zero register (ZERO_REG=1):
  - Write 0xFF to reg 0 with x_sel=0 on the same edge: x=0.
  - busy_set to reg 0: x_busy stays 0.
- Width/depth:
  - Instantiate with b=16, N_b=5.
  - Write 0xBEEF to reg 31 → x=0xBEEF after the read edge; reg 30 still reads 0.
